// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl_if
//  Description : Handshake and operand bundle between the EXE stage and the
//                iterative divide controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_ctrl_if;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // Pipeline side: issues the divide and consumes the result
    modport master (
        output start, signed_op, dividend, divisor, cancel,
        input  stall, busy, done, quotient, remainder
    );

    // Divider side
    modport slave (
        input  start, signed_op, dividend, divisor, cancel,
        output stall, busy, done, quotient, remainder
    );
endinterface
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Iterative radix-2 restoring divide controller for DIV/DIVU.
//                Produces one quotient bit per cycle, stalls the front of the
//                pipeline while running and returns registered HI/LO values.
//  Revision    : 1.0  initial release
// ============================================================================
module div_ctrl #(
    parameter int ITER = 32
) (
    input  wire logic  clk,
    input  wire logic  reset,
    div_ctrl_if.slave  bus
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(ITER - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [32:0]      r_rem;
    logic [31:0]      r_q;
    logic [31:0]      r_dvsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [31:0]      r_quotient;
    logic [31:0]      r_remainder;

    logic             w_issue;
    logic             w_div_zero;
    logic             w_in_busy;
    logic [31:0]      w_dvd_abs;
    logic [31:0]      w_dvs_abs;
    logic [33:0]      w_shift;
    logic [33:0]      w_diff;
    logic             w_take;
    logic [32:0]      w_rem_next;
    logic [31:0]      w_q_next;
    logic             w_last;
    logic [31:0]      w_q_fin;
    logic [31:0]      w_r_fin;

    // Issue decode, operand magnitudes and one restoring-division step
    always_comb begin
        w_issue    = (r_state == c_st_idle) & bus.start & ~bus.cancel;
        w_div_zero = (bus.divisor == 32'd0);
        w_in_busy  = (r_state == c_st_busy);

        // Magnitudes only for DIV; 0x80000000 maps onto itself, which is the
        // correct unsigned magnitude 2^31.
        w_dvd_abs  = (bus.signed_op & bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
        w_dvs_abs  = (bus.signed_op & bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;

        // {rem, q} << 1, then trial subtract; the borrow (bit 33) says whether
        // the divisor fits.
        w_shift    = {r_rem, r_q[31]};
        w_diff     = w_shift - {2'b00, r_dvsr};
        w_take     = ~w_diff[33];
        w_rem_next = w_take ? w_diff[32:0] : w_shift[32:0];
        w_q_next   = {r_q[30:0], w_take};
        w_last     = (r_cnt == c_last);

        // Sign fix-up applied on the final iteration, modulo 2^32
        w_q_fin    = r_q_neg ? (32'd0 - w_q_next) : w_q_next;
        w_r_fin    = r_r_neg ? (32'd0 - w_rem_next[31:0]) : w_rem_next[31:0];
    end

    // Control FSM and iteration datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_rem   <= '0;
            r_q     <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_issue) begin
                        if (w_div_zero) begin
                            r_state <= c_st_done;
                        end else begin
                            r_state <= c_st_busy;
                            r_q     <= w_dvd_abs;
                            r_dvsr  <= w_dvs_abs;
                            r_q_neg <= bus.signed_op & (bus.dividend[31] ^ bus.divisor[31]);
                            r_r_neg <= bus.signed_op & bus.dividend[31];
                            r_rem   <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                c_st_busy: begin
                    if (bus.cancel) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_rem <= w_rem_next;
                        r_q   <= w_q_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    // Cancel or not, DONE always lasts one cycle; start is
                    // ignored because the issuing instruction advances now.
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Result registers: updated only by a divide-by-zero issue or a
    // completed, uncancelled final iteration
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_issue && w_div_zero) begin
            r_quotient  <= 32'hFFFF_FFFF;
            r_remainder <= bus.dividend;
        end else if (w_in_busy && !bus.cancel && w_last) begin
            r_quotient  <= w_q_fin;
            r_remainder <= w_r_fin;
        end
    end

    // Stall is combinational so ID freezes in the issue cycle itself
    assign bus.stall     = w_issue | (w_in_busy & ~bus.cancel);
    assign bus.busy      = w_in_busy;
    assign bus.done      = (r_state == c_st_done) & ~bus.cancel;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Self-checking bench for div_ctrl with a result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_ctrl;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    res_t        sb[$];
    res_t        mon_e;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    div_ctrl_if bus ();

    div_ctrl #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, with MIPS divide-by-zero and overflow results
    function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        res_t m;
        if (b == 32'd0) begin
            m.q = 32'hFFFF_FFFF;
            m.r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m.q = 32'h8000_0000;
            m.r = 32'd0;
        end else if (s) begin
            m.q = $signed(a) / $signed(b);
            m.r = $signed(a) % $signed(b);
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", bus.quotient, mon_e.q);
                check("remainder", bus.remainder, mon_e.r);
                last_q = mon_e.q;
                last_r = mon_e.r;
            end
        end
    end

    // Issue one divide in the current cycle and follow it to completion.
    // chain=1 leaves start high after DONE so the next call issues back-to-back.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q_e, input logic [31:0] r_e,
                           input bit mutate, input bit chain);
        int n;
        bit seen;
        sb.push_back('{q_e, r_e});
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.cancel    = 1'b0;
        #1;
        check("stall_issue", {31'd0, bus.stall}, 32'd1);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            cycle();
            n++;
            if (mutate) begin
                bus.dividend = ~a;
                bus.divisor  = b ^ 32'h0000_0005;
            end
            #1;
            if (bus.done === 1'b1) begin
                seen = 1;
                check("latency", n, (b == 32'd0) ? 32'd1 : 32'd33);
                check("stall_done", {31'd0, bus.stall}, 32'd0);
            end else if (bus.stall !== 1'b1) begin
                check("stall_busy", {31'd0, bus.stall}, 32'd1);
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end
        cycle();
        if (!chain) begin
            bus.start = 1'b0;
            #1;
            check("no_restart_busy", {31'd0, bus.busy}, 32'd0);
            check("no_restart_stall", {31'd0, bus.stall}, 32'd0);
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        res_t m;
        logic s;
        logic [31:0] a;
        logic [31:0] b;

        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.cancel    = 1'b0;

        // Reset state
        repeat (2) cycle();
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        reset = 1'b1;
        cycle();

        // Directed cases
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 1);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 1);
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 0);
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, 0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, 0);
        run_div(1'b1, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 32'hFFFF_FFFA, 1, 0);

        // Cancel in BUSY cycle 10, then a new divide in cycle 12
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            cycle();
        end
        bus.cancel = 1'b1;
        #1;
        check("stall_cancel", {31'd0, bus.stall}, 32'd0);
        cycle();
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        #1;
        check("cancel_idle", {31'd0, bus.busy}, 32'd0);
        check("cancel_keep_q", bus.quotient, last_q);
        check("cancel_keep_r", bus.remainder, last_r);
        cycle();
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0);

        // Reset asserted in cycle 15 of a running divide
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd100000;
        bus.divisor   = 32'd13;
        for (int k = 1; k <= 15; k++) begin
            cycle();
        end
        reset = 1'b0;
        cycle();
        bus.start = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_quotient", bus.quotient, 32'd0);
        check("mid_rst_remainder", bus.remainder, 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        run_div(1'b0, 32'd100000, 32'd13, 32'd7692, 32'd4, 0, 0);

        // Randomised operands against the reference model
        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            m = model(s, a, b);
            run_div(s, a, b, m.q, m.r, i[0], 0);
        end

        repeat (3) cycle();
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
